// File: rtl/digit_glyph_rom_pkg.sv
// Glyph geometry, segment rectangles and the digit-to-segment table shared by
// the address decoder and the pixel ROM top.
package digit_glyph_pkg;

  localparam int GLYPH_W    = 30;
  localparam int GLYPH_H    = 30;
  localparam int GLYPH_PIX  = GLYPH_W * GLYPH_H;
  localparam int MAX_DIGITS = 10;
  localparam int NUM_SEGS   = 7;

  // ceil(2^16/30): floor(pix*ROW_RECIP >> 16) equals pix/30 for every pix < 900
  localparam int ROW_RECIP = 2185;
  localparam int ROW_SHIFT = 16;

  localparam logic [4:0] ROW_A0  = 5'd2;
  localparam logic [4:0] ROW_A1  = 5'd5;
  localparam logic [4:0] ROW_G0  = 5'd13;
  localparam logic [4:0] ROW_G1  = 5'd16;
  localparam logic [4:0] ROW_D0  = 5'd24;
  localparam logic [4:0] ROW_D1  = 5'd27;
  localparam logic [4:0] ROW_UP0 = 5'd2;
  localparam logic [4:0] ROW_UP1 = 5'd16;
  localparam logic [4:0] ROW_LO0 = 5'd13;
  localparam logic [4:0] ROW_LO1 = 5'd27;
  localparam logic [4:0] COL_H0  = 5'd5;
  localparam logic [4:0] COL_H1  = 5'd24;
  localparam logic [4:0] COL_L0  = 5'd5;
  localparam logic [4:0] COL_L1  = 5'd8;
  localparam logic [4:0] COL_R0  = 5'd21;
  localparam logic [4:0] COL_R1  = 5'd24;

  // bit 0 = segment a ... bit 6 = segment g
  typedef logic [6:0] seg_mask_t;

  typedef struct packed {
    logic [4:0] r0;
    logic [4:0] r1;
    logic [4:0] c0;
    logic [4:0] c1;
  } seg_rect_t;

  localparam seg_rect_t SEG_RECT [NUM_SEGS] = '{
    '{ROW_A0,  ROW_A1,  COL_H0, COL_H1},   // a
    '{ROW_UP0, ROW_UP1, COL_R0, COL_R1},   // b
    '{ROW_LO0, ROW_LO1, COL_R0, COL_R1},   // c
    '{ROW_D0,  ROW_D1,  COL_H0, COL_H1},   // d
    '{ROW_LO0, ROW_LO1, COL_L0, COL_L1},   // e
    '{ROW_UP0, ROW_UP1, COL_L0, COL_L1},   // f
    '{ROW_G0,  ROW_G1,  COL_H0, COL_H1}    // g
  };

  localparam seg_mask_t SEG_TABLE [MAX_DIGITS] = '{
    7'b0111111,  // 0
    7'b0000110,  // 1
    7'b1011011,  // 2
    7'b1001111,  // 3
    7'b1100110,  // 4
    7'b1101101,  // 5
    7'b1111101,  // 6
    7'b0000111,  // 7
    7'b1111111,  // 8
    7'b1101111   // 9
  };

  function automatic seg_mask_t seg_mask_for(input logic [3:0] d);
    return (d < 4'(MAX_DIGITS)) ? SEG_TABLE[d] : '0;
  endfunction

  function automatic logic [13:0] digit_base(input logic [3:0] d);
    return 14'(d) * 14'(GLYPH_PIX);
  endfunction

  function automatic logic in_rect(input logic [4:0] row, input logic [4:0] col,
                                   input seg_rect_t rect);
    return (row >= rect.r0) && (row <= rect.r1) && (col >= rect.c0) && (col <= rect.c1);
  endfunction

endpackage

// File: rtl/digit_glyph_rom_if.sv
// Pixel-address / pixel-data port between the countdown renderer (master)
// and the glyph ROM (slave).
interface digit_glyph_rom_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              q;

  modport master (output address, input q);
  modport slave  (input address, output q);
endinterface

// File: rtl/digit_glyph_addr_decode.sv
// Combinational split of a flat pixel address into {valid, digit, row, col}
// using a compare ladder for the digit and a reciprocal multiply for the row.
module digit_glyph_addr_decode
  import digit_glyph_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_DIGITS = 10
) (
  input  logic [ADDR_W-1:0] address,
  output logic              valid,
  output logic [3:0]        digit,
  output logic [4:0]        row,
  output logic [4:0]        col
);

  logic [9:0] pix;

  always_comb begin
    valid = address < ADDR_W'(NUM_DIGITS * GLYPH_PIX);
    digit = '0;
    for (int k = 1; k < MAX_DIGITS; k++) begin
      if (k < NUM_DIGITS && address >= ADDR_W'(k * GLYPH_PIX)) begin
        digit = 4'(k);
      end
    end
    // only meaningful when valid, where the address fits in 14 bits
    pix = 10'(address[13:0] - digit_base(digit));
    row = 5'((22'(pix) * 22'(ROW_RECIP)) >> ROW_SHIFT);
    col = 5'(pix - 10'(row) * 10'(GLYPH_W));
  end

endmodule

// File: rtl/digit_glyph_rom.sv
// Seven-segment digit glyph pixel ROM, active-low ink, 1-cycle read latency.
// Define DIGIT_ROM_OUTREG_EN to add a second output register (2-cycle latency).
module digit_glyph_rom
  import digit_glyph_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_DIGITS = 10
) (
  input  logic               clock,
  input  logic               reset,
  digit_glyph_rom_if.slave   bus
);

  logic      valid;
  logic [3:0] digit;
  logic [4:0] row;
  logic [4:0] col;
  seg_mask_t mask;
  logic      ink;
  logic      q_s1;

  digit_glyph_addr_decode #(
    .ADDR_W     (ADDR_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_decode (
    .address (bus.address),
    .valid   (valid),
    .digit   (digit),
    .row     (row),
    .col     (col)
  );

  always_comb begin
    mask = valid ? seg_mask_for(digit) : '0;
    ink  = 1'b0;
    for (int s = 0; s < NUM_SEGS; s++) begin
      if (mask[s] && in_rect(row, col, SEG_RECT[s])) begin
        ink = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_s1 <= 1'b1;
    end else begin
      q_s1 <= ~ink;
    end
  end

`ifdef DIGIT_ROM_OUTREG_EN
  logic q_s2;

  always_ff @(posedge clock) begin
    if (reset) begin
      q_s2 <= 1'b1;
    end else begin
      q_s2 <= q_s1;
    end
  end

  assign bus.q = q_s2;
`else
  assign bus.q = q_s1;
`endif

endmodule

// File: tb/tb_digit_glyph_rom.sv
// Scoreboard bench for digit_glyph_rom: 10-digit and 9-digit instances share
// one address stream; expected pixels come from a string-based glyph model.
module tb_digit_glyph_rom;

`ifdef DIGIT_ROM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;

  digit_glyph_rom_if #(.ADDR_W(32)) bus10 ();
  digit_glyph_rom_if #(.ADDR_W(32)) bus9 ();

  digit_glyph_rom #(.ADDR_W(32), .NUM_DIGITS(10)) dut10 (
    .clock (clock),
    .reset (reset),
    .bus   (bus10)
  );

  digit_glyph_rom #(.ADDR_W(32), .NUM_DIGITS(9)) dut9 (
    .clock (clock),
    .reset (reset),
    .bus   (bus9)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic        rst;
    logic        exp10;
    logic        exp9;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  string seg_names [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic ref_q(input logic [31:0] a, input int nd);
    int    d, p, r, c;
    string s;
    logic  hit;
    if (a >= 32'(nd * 900)) return 1'b1;
    d = int'(a / 900);
    p = int'(a % 900);
    r = p / 30;
    c = p % 30;
    s = seg_names[d];
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a":     hit = (r >= 2  && r <= 5  && c >= 5  && c <= 24);
        "b":     hit = (r >= 2  && r <= 16 && c >= 21 && c <= 24);
        "c":     hit = (r >= 13 && r <= 27 && c >= 21 && c <= 24);
        "d":     hit = (r >= 24 && r <= 27 && c >= 5  && c <= 24);
        "e":     hit = (r >= 13 && r <= 27 && c >= 5  && c <= 8);
        "f":     hit = (r >= 2  && r <= 16 && c >= 5  && c <= 8);
        "g":     hit = (r >= 13 && r <= 16 && c >= 5  && c <= 24);
        default: hit = 1'b0;
      endcase
      if (hit) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got q=%b expected q=%b", tag, obs, exp);
    end
  endtask

  // One clock: compare the oldest in-flight entry, then drive the next input.
  task automatic cycle(input logic [31:0] addr, input logic rst);
    sb_t e;
    @(negedge clock);
    if (sb_q.size() == LAT) begin
      e = sb_q.pop_front();
      check_bit($sformatf("q10 addr=%0d rst=%b", e.addr, e.rst), bus10.q, e.exp10);
      check_bit($sformatf("q9 addr=%0d rst=%b", e.addr, e.rst), bus9.q, e.exp9);
    end
    reset         = rst;
    bus10.address = addr;
    bus9.address  = addr;
    if (rst) begin
      foreach (sb_q[i]) begin
        sb_q[i].exp10 = 1'b1;
        sb_q[i].exp9  = 1'b1;
      end
    end
    e.addr  = addr;
    e.rst   = rst;
    e.exp10 = rst ? 1'b1 : ref_q(addr, 10);
    e.exp9  = rst ? 1'b1 : ref_q(addr, 9);
    sb_q.push_back(e);
  endtask

  logic [31:0] directed [12] = '{32'd0, 32'd100, 32'd432, 32'd1332, 32'd1522, 32'd7632,
                                 32'd9000, 32'hFFFF_FFFF, 32'd8100, 32'd8200,
                                 32'd8099, 32'd8999};

  initial begin
    bus10.address = 32'd100;
    bus9.address  = 32'd100;

    for (int i = 0; i < 3; i++) cycle(32'd100, 1'b1);

    foreach (directed[i]) cycle(directed[i], 1'b0);

    for (int a = 0; a < 9100; a++) cycle(32'(a), 1'b0);

    for (int a = 2000; a < 2200; a++) begin
      cycle(32'(a), (a == 2100 || a == 2101));
    end

    for (int i = 0; i < LAT + 1; i++) cycle(32'hFFFF_FFFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
